// File: rtl/psum_collector.sv
// psum_collector
//   Collects partial sums from the last PE of one systolic-array column into a
//   local buffer of 2**ADDR_W signed entries. A valid psum is captured on one
//   edge and written on the next, either overwriting the entry or adding to it
//   with saturation. The controller drains entries through a registered read
//   port that can clear the entry it reads. An accepted-psum counter raises a
//   one-cycle Done pulse when it reaches Exp_Cnt. Ovf_Flag records any clamp.
//
// Ports
//   CLK, RST    clock; synchronous active-high reset
//   Psum_In     signed psum from the last PE (PSUM_W)
//   Addr_P_In   destination entry of Psum_In
//   Valid_P_In  bit 0 qualifies Psum_In/Addr_P_In
//   Acc_Mode    1 = accumulate into entry, 0 = overwrite entry
//   Exp_Cnt     psum count that fires Done (0 = never)
//   Rd_Req      read request; Rd_Addr selects the entry
//   Rd_Clr      with Rd_Req: zero the entry after reading it
//   Rd_Data     registered read data (holds when no request)
//   Rd_Valid    one-cycle pulse qualifying Rd_Data
//   Psum_Cnt    psums accepted since reset / Cnt_Clr (wraps)
//   Cnt_Clr     zero Psum_Cnt and Ovf_Flag
//   Done        one-cycle pulse when Psum_Cnt reaches Exp_Cnt
//   Ovf_Flag    sticky saturation indicator
module psum_collector #(
    parameter int PSUM_W  = 16,
    parameter int ADDR_W  = 4,
    parameter int VALID_W = 1,
    parameter int ACC_W   = 32,
    parameter int CNT_W   = 16
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic [PSUM_W-1:0]   Psum_In,
    input  logic [ADDR_W-1:0]   Addr_P_In,
    input  logic [VALID_W-1:0]  Valid_P_In,
    input  logic                Acc_Mode,
    input  logic [CNT_W-1:0]    Exp_Cnt,
    input  logic                Rd_Req,
    input  logic [ADDR_W-1:0]   Rd_Addr,
    input  logic                Rd_Clr,
    output logic [ACC_W-1:0]    Rd_Data,
    output logic                Rd_Valid,
    output logic [CNT_W-1:0]    Psum_Cnt,
    input  logic                Cnt_Clr,
    output logic                Done,
    output logic                Ovf_Flag
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    // Stage-1 capture register
    logic               s1_vld_q;
    logic [ACC_W-1:0]   s1_psum_q;
    logic [ADDR_W-1:0]  s1_addr_q;
    logic               s1_acc_q;

    logic [ACC_W-1:0]   mem_q [DEPTH];

    logic [ACC_W-1:0]   rd_data_q;
    logic               rd_valid_q;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               done_q, done_d;
    logic               ovf_q, ovf_d;

    logic               cap;
    logic [ACC_W-1:0]   psum_ext;
    logic               clr_hit;
    logic [ACC_W-1:0]   base;
    logic [ACC_W:0]     sum_wide;
    logic               sat_hi, sat_lo;
    logic [ACC_W-1:0]   acc_val;
    logic [ACC_W-1:0]   entry_d;
    logic               clamp;
    logic [CNT_W-1:0]   cnt_base;

    always_comb begin
        cap      = Valid_P_In[0];
        psum_ext = ACC_W'($signed(Psum_In));

        // A clear-on-read of the entry being written this edge makes the
        // write start from zero instead of the stale stored value.
        clr_hit  = Rd_Req && Rd_Clr && (Rd_Addr == s1_addr_q);
        base     = clr_hit ? '0 : mem_q[s1_addr_q];

        // One guard bit: the top two bits differ exactly when the sum left
        // the representable range.
        sum_wide = {base[ACC_W-1], base} + {s1_psum_q[ACC_W-1], s1_psum_q};
        sat_hi   = ~sum_wide[ACC_W] &  sum_wide[ACC_W-1];
        sat_lo   =  sum_wide[ACC_W] & ~sum_wide[ACC_W-1];
        if (sat_hi)
            acc_val = ACC_MAX;
        else if (sat_lo)
            acc_val = ACC_MIN;
        else
            acc_val = sum_wide[ACC_W-1:0];

        entry_d  = s1_acc_q ? acc_val : s1_psum_q;
        clamp    = s1_vld_q && s1_acc_q && (sat_hi || sat_lo);

        cnt_base = Cnt_Clr ? '0 : cnt_q;
        cnt_d    = cnt_base + CNT_W'(cap);
        done_d   = cap && (cnt_d == Exp_Cnt) && (Exp_Cnt != '0);

        // A clamp on the same edge as Cnt_Clr still registers.
        ovf_d    = (ovf_q && !Cnt_Clr) || clamp;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            s1_vld_q   <= 1'b0;
            s1_psum_q  <= '0;
            s1_addr_q  <= '0;
            s1_acc_q   <= 1'b0;
            mem_q      <= '{default: '0};
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            cnt_q      <= '0;
            done_q     <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            s1_vld_q <= cap;
            if (cap) begin
                s1_psum_q <= psum_ext;
                s1_addr_q <= Addr_P_In;
                s1_acc_q  <= Acc_Mode;
            end

            rd_valid_q <= Rd_Req;
            if (Rd_Req)
                rd_data_q <= mem_q[Rd_Addr];

            // Stage-1 write comes after the clear so it wins on a collision.
            if (Rd_Req && Rd_Clr)
                mem_q[Rd_Addr] <= '0;
            if (s1_vld_q)
                mem_q[s1_addr_q] <= entry_d;

            cnt_q  <= cnt_d;
            done_q <= done_d;
            ovf_q  <= ovf_d;
        end
    end

    assign Rd_Data  = rd_data_q;
    assign Rd_Valid = rd_valid_q;
    assign Psum_Cnt = cnt_q;
    assign Done     = done_q;
    assign Ovf_Flag = ovf_q;

endmodule

// File: tb/tb_psum_collector.sv
// tb_psum_collector
//   Directed scenarios plus a randomized stream checked against a sequential
//   arithmetic model of the entry buffer, counter and overflow flag.
//   Inputs change 1 time unit after each rising edge; outputs are sampled there.
module tb_psum_collector;

    logic        CLK;
    logic        RST;
    logic [31:0] Psum_In;
    logic [2:0]  Addr_P_In;
    logic [0:0]  Valid_P_In;
    logic        Acc_Mode;
    logic [15:0] Exp_Cnt;
    logic        Rd_Req;
    logic [2:0]  Rd_Addr;
    logic        Rd_Clr;
    logic [31:0] Rd_Data;
    logic        Rd_Valid;
    logic [15:0] Psum_Cnt;
    logic        Cnt_Clr;
    logic        Done;
    logic        Ovf_Flag;

    int total = 0;
    int bad   = 0;

    psum_collector #(
        .PSUM_W (32),
        .ADDR_W (3),
        .VALID_W(1),
        .ACC_W  (32),
        .CNT_W  (16)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .Psum_In   (Psum_In),
        .Addr_P_In (Addr_P_In),
        .Valid_P_In(Valid_P_In),
        .Acc_Mode  (Acc_Mode),
        .Exp_Cnt   (Exp_Cnt),
        .Rd_Req    (Rd_Req),
        .Rd_Addr   (Rd_Addr),
        .Rd_Clr    (Rd_Clr),
        .Rd_Data   (Rd_Data),
        .Rd_Valid  (Rd_Valid),
        .Psum_Cnt  (Psum_Cnt),
        .Cnt_Clr   (Cnt_Clr),
        .Done      (Done),
        .Ovf_Flag  (Ovf_Flag)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic step;
        @(posedge CLK);
        #1;
    endtask

    // Present one valid psum for exactly one edge.
    task automatic send(input logic [31:0] p, input logic [2:0] a, input logic md);
        Psum_In    = p;
        Addr_P_In  = a;
        Acc_Mode   = md;
        Valid_P_In = 1'b1;
        step();
        Valid_P_In = 1'b0;
    endtask

    task automatic read_entry(input logic [2:0] a, input logic clr,
                              output logic [31:0] d, output logic v);
        Rd_Req  = 1'b1;
        Rd_Addr = a;
        Rd_Clr  = clr;
        step();
        d = Rd_Data;
        v = Rd_Valid;
        Rd_Req = 1'b0;
        Rd_Clr = 1'b0;
    endtask

    task automatic clear_count;
        Cnt_Clr = 1'b1;
        step();
        Cnt_Clr = 1'b0;
    endtask

    task automatic test_reset;
        logic [31:0] d;
        logic v;
        RST        = 1'b1;
        Valid_P_In = 1'b1;
        Psum_In    = 32'd99;
        Addr_P_In  = 3'd0;
        Acc_Mode   = 1'b0;
        step();
        RST        = 1'b0;
        Valid_P_In = 1'b0;
        total++; if (Rd_Data !== 32'd0) begin bad++; $display("FAIL reset_rd_data got=%0h want=0", Rd_Data); end
        total++; if (Rd_Valid !== 1'b0) begin bad++; $display("FAIL reset_rd_valid got=%b want=0", Rd_Valid); end
        total++; if (Psum_Cnt !== 16'd0) begin bad++; $display("FAIL reset_cnt got=%0d want=0", Psum_Cnt); end
        total++; if (Done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", Done); end
        total++; if (Ovf_Flag !== 1'b0) begin bad++; $display("FAIL reset_ovf got=%b want=0", Ovf_Flag); end
        step();
        step();
        read_entry(3'd0, 1'b0, d, v);
        total++; if (d !== 32'd0) begin bad++; $display("FAIL reset_entry0 got=%0d want=0", d); end
    endtask

    task automatic test_accumulate;
        logic [31:0] d;
        logic v;
        send(32'd5, 3'd2, 1'b1);
        send(-32'sd3, 3'd2, 1'b1);
        send(32'd10, 3'd2, 1'b1);
        total++; if (Psum_Cnt !== 16'd3) begin bad++; $display("FAIL acc_cnt got=%0d want=3", Psum_Cnt); end
        step();
        read_entry(3'd2, 1'b0, d, v);
        total++; if (d !== 32'd12) begin bad++; $display("FAIL acc_data got=%0d want=12", $signed(d)); end
        total++; if (v !== 1'b1) begin bad++; $display("FAIL acc_rd_valid got=%b want=1", v); end
        step();
        total++; if (Rd_Valid !== 1'b0) begin bad++; $display("FAIL acc_rd_valid_drop got=%b want=0", Rd_Valid); end
        total++; if (Rd_Data !== 32'd12) begin bad++; $display("FAIL acc_rd_hold got=%0d want=12", Rd_Data); end
    endtask

    task automatic test_overwrite_done;
        logic [31:0] d;
        logic v;
        Exp_Cnt = 16'd4;
        clear_count();
        total++; if (Psum_Cnt !== 16'd0) begin bad++; $display("FAIL ow_cnt_clr got=%0d want=0", Psum_Cnt); end
        send(32'd100, 3'd7, 1'b0);
        total++; if (Done !== 1'b0) begin bad++; $display("FAIL ow_done1 got=%b want=0", Done); end
        send(32'd4, 3'd7, 1'b0);
        total++; if (Done !== 1'b0) begin bad++; $display("FAIL ow_done2 got=%b want=0", Done); end
        send(32'd11, 3'd0, 1'b0);
        total++; if (Done !== 1'b0) begin bad++; $display("FAIL ow_done3 got=%b want=0", Done); end
        send(32'd12, 3'd1, 1'b0);
        total++; if (Done !== 1'b1) begin bad++; $display("FAIL ow_done4 got=%b want=1", Done); end
        total++; if (Psum_Cnt !== 16'd4) begin bad++; $display("FAIL ow_cnt got=%0d want=4", Psum_Cnt); end
        step();
        total++; if (Done !== 1'b0) begin bad++; $display("FAIL ow_done_pulse got=%b want=0", Done); end
        read_entry(3'd7, 1'b0, d, v);
        total++; if (d !== 32'd4) begin bad++; $display("FAIL ow_data got=%0d want=4", d); end
        Exp_Cnt = 16'd0;
        clear_count();
        total++; if (Done !== 1'b0) begin bad++; $display("FAIL ow_exp0_done got=%b want=0", Done); end
    endtask

    task automatic test_saturation;
        logic [31:0] d;
        logic v;
        clear_count();
        total++; if (Ovf_Flag !== 1'b0) begin bad++; $display("FAIL sat_ovf_init got=%b want=0", Ovf_Flag); end
        send(32'h7FFF_FFF6, 3'd4, 1'b0);
        send(32'd20, 3'd4, 1'b1);
        step();
        total++; if (Ovf_Flag !== 1'b1) begin bad++; $display("FAIL sat_ovf_set got=%b want=1", Ovf_Flag); end
        read_entry(3'd4, 1'b0, d, v);
        total++; if (d !== 32'h7FFF_FFFF) begin bad++; $display("FAIL sat_pos got=%0h want=7fffffff", d); end
        send(32'h8000_0005, 3'd5, 1'b0);
        send(-32'sd10, 3'd5, 1'b1);
        step();
        read_entry(3'd5, 1'b0, d, v);
        total++; if (d !== 32'h8000_0000) begin bad++; $display("FAIL sat_neg got=%0h want=80000000", d); end
        step(); step(); step();
        total++; if (Ovf_Flag !== 1'b1) begin bad++; $display("FAIL sat_ovf_sticky got=%b want=1", Ovf_Flag); end
        clear_count();
        total++; if (Ovf_Flag !== 1'b0) begin bad++; $display("FAIL sat_ovf_clr got=%b want=0", Ovf_Flag); end
        Cnt_Clr = 1'b1;
        send(32'd1, 3'd6, 1'b0);
        Cnt_Clr = 1'b0;
        total++; if (Psum_Cnt !== 16'd1) begin bad++; $display("FAIL sat_clr_with_valid got=%0d want=1", Psum_Cnt); end
        step();
    endtask

    task automatic test_clear_collision;
        logic [31:0] d;
        logic v;
        send(32'd50, 3'd3, 1'b0);
        step();
        send(32'd7, 3'd3, 1'b1);
        read_entry(3'd3, 1'b1, d, v);
        total++; if (d !== 32'd50) begin bad++; $display("FAIL col_pre got=%0d want=50", d); end
        read_entry(3'd3, 1'b0, d, v);
        total++; if (d !== 32'd7) begin bad++; $display("FAIL col_after got=%0d want=7", d); end
        read_entry(3'd3, 1'b1, d, v);
        total++; if (d !== 32'd7) begin bad++; $display("FAIL col_clr_read got=%0d want=7", d); end
        read_entry(3'd3, 1'b0, d, v);
        total++; if (d !== 32'd0) begin bad++; $display("FAIL col_cleared got=%0d want=0", d); end
        send(32'd30, 3'd6, 1'b0);
        send(32'd9, 3'd3, 1'b0);
        step();
        send(32'd1, 3'd6, 1'b1);
        read_entry(3'd3, 1'b1, d, v);
        total++; if (d !== 32'd9) begin bad++; $display("FAIL indep_rd got=%0d want=9", d); end
        read_entry(3'd6, 1'b0, d, v);
        total++; if (d !== 32'd31) begin bad++; $display("FAIL indep_wr got=%0d want=31", d); end
        read_entry(3'd3, 1'b0, d, v);
        total++; if (d !== 32'd0) begin bad++; $display("FAIL indep_clr got=%0d want=0", d); end
    endtask

    task automatic test_midstream_reset;
        logic [31:0] d;
        logic v;
        Exp_Cnt = 16'd1;
        clear_count();
        send(32'd77, 3'd1, 1'b0);
        total++; if (Psum_Cnt !== 16'd1) begin bad++; $display("FAIL mid_cap_cnt got=%0d want=1", Psum_Cnt); end
        RST = 1'b1;
        step();
        RST = 1'b0;
        total++; if (Psum_Cnt !== 16'd0) begin bad++; $display("FAIL mid_cnt got=%0d want=0", Psum_Cnt); end
        total++; if (Done !== 1'b0) begin bad++; $display("FAIL mid_done got=%b want=0", Done); end
        step();
        total++; if (Done !== 1'b0) begin bad++; $display("FAIL mid_done_late got=%b want=0", Done); end
        step();
        read_entry(3'd1, 1'b0, d, v);
        total++; if (d !== 32'd0) begin bad++; $display("FAIL mid_entry got=%0d want=0", d); end
        Exp_Cnt = 16'd0;
    endtask

    task automatic test_random;
        longint m [8];
        longint pv, s;
        int cnt;
        bit ovf, vv, md, clr, exp_done;
        logic [2:0] a;
        logic [31:0] p, d;
        logic v;
        logic [15:0] ex;
        bit cleared [8];
        RST = 1'b1;
        step();
        RST = 1'b0;
        for (int i = 0; i < 8; i++) m[i] = 0;
        cnt = 0;
        ovf = 0;
        ex = 16'($urandom_range(20, 120));
        Exp_Cnt = ex;
        for (int n = 0; n < 200; n++) begin
            vv = ($urandom_range(0, 9) < 7);
            a  = 3'($urandom_range(0, 7));
            md = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 4) == 0)
                p = $urandom;
            else
                p = 32'(int'($urandom_range(0, 2000)) - 1000);
            Valid_P_In = vv;
            Psum_In    = p;
            Addr_P_In  = a;
            Acc_Mode   = md;
            step();
            exp_done = 0;
            if (vv) begin
                pv = longint'($signed(p));
                if (md) begin
                    s = m[a] + pv;
                    if (s > 64'sd2147483647) begin s = 64'sd2147483647; ovf = 1; end
                    else if (s < -64'sd2147483648) begin s = -64'sd2147483648; ovf = 1; end
                    m[a] = s;
                end else begin
                    m[a] = pv;
                end
                cnt++;
                exp_done = (cnt == int'(ex));
            end
            total++; if (Done !== exp_done) begin bad++; $display("FAIL rnd_done n=%0d got=%b want=%b", n, Done, exp_done); end
        end
        Valid_P_In = 1'b0;
        step();
        total++; if (Psum_Cnt !== 16'(cnt)) begin bad++; $display("FAIL rnd_cnt got=%0d want=%0d", Psum_Cnt, cnt); end
        total++; if (Ovf_Flag !== ovf) begin bad++; $display("FAIL rnd_ovf got=%b want=%b", Ovf_Flag, ovf); end
        for (int i = 0; i < 8; i++) begin
            clr = 1'($urandom_range(0, 1));
            read_entry(3'(i), clr, d, v);
            s = m[i];
            total++; if (d !== s[31:0] || v !== 1'b1) begin bad++; $display("FAIL rnd_entry a=%0d got=%0h/%b want=%0h/1", i, d, v, s[31:0]); end
            cleared[i] = clr;
            if (clr) m[i] = 0;
        end
        for (int i = 0; i < 8; i++) begin
            read_entry(3'(i), 1'b0, d, v);
            s = m[i];
            total++; if (d !== s[31:0]) begin bad++; $display("FAIL rnd_reread a=%0d clr=%b got=%0h want=%0h", i, cleared[i], d, s[31:0]); end
        end
        Exp_Cnt = 16'd0;
    endtask

    initial begin
        RST        = 1'b1;
        Psum_In    = '0;
        Addr_P_In  = '0;
        Valid_P_In = '0;
        Acc_Mode   = 1'b0;
        Exp_Cnt    = '0;
        Rd_Req     = 1'b0;
        Rd_Addr    = '0;
        Rd_Clr     = 1'b0;
        Cnt_Clr    = 1'b0;
        step();
        step();
        RST = 1'b0;
        step();
        test_reset();
        test_accumulate();
        test_overwrite_done();
        test_saturation();
        test_clear_collision();
        test_midstream_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
